// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one memory read at a time, holds the
// returned instruction for decode, and handles branch/jump redirects and halt.
module fetch_sequencer (
  input  logic       clk,
  input  logic       reset,
  output logic       imem_req,
  output logic [9:0] imem_addr,
  input  logic       imem_ack,
  input  logic [8:0] imem_rdata,
  input  logic       branch,
  input  logic [9:0] branch_addr,
  input  logic       jump,
  input  logic [9:0] jump_target,
  input  logic       halt,
  output logic       inst_valid,
  output logic [8:0] inst,
  output logic [9:0] inst_pc,
  input  logic       inst_ready,
  output logic [9:0] pc_out
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

  state_t     state, state_nxt;
  logic [9:0] pc, pc_nxt;
  logic [9:0] ipc, ipc_nxt;
  logic [8:0] ir, ir_nxt;
  logic       pend, pend_nxt;
  logic [9:0] tgt, tgt_nxt;
  logic       redirect;
  logic [9:0] redir_target;

  assign redirect     = jump | branch;
  assign redir_target = jump ? jump_target : branch_addr;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ipc_nxt   = ipc;
    ir_nxt    = ir;
    pend_nxt  = pend;
    tgt_nxt   = tgt;
    case (state)
      IDLE: begin
        if (redirect) pc_nxt = redir_target;
        state_nxt = halt ? HALT : REQ;
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect || pend) begin
            // Returned word belongs to the old stream; a same-cycle redirect beats the stored one.
            pc_nxt   = redirect ? redir_target : tgt;
            pend_nxt = 1'b0;
          end else begin
            ir_nxt    = imem_rdata;
            ipc_nxt   = pc;
            pc_nxt    = pc + 10'd1;
            state_nxt = HOLD;
          end
        end else if (redirect) begin
          pend_nxt = 1'b1;
          tgt_nxt  = redir_target;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt    = redir_target;
          state_nxt = REQ;
        end else if (inst_ready) begin
          state_nxt = halt ? HALT : REQ;
        end
      end
      HALT: begin
        if (redirect) pc_nxt = redir_target;
        if (!halt) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      ipc   <= '0;
      ir    <= '0;
      pend  <= 1'b0;
      tgt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ipc   <= ipc_nxt;
      ir    <= ir_nxt;
      pend  <= pend_nxt;
      tgt   <= tgt_nxt;
    end
  end

  assign imem_req   = (state == REQ);
  assign inst_valid = (state == HOLD);
  assign imem_addr  = pc;
  assign pc_out     = pc;
  assign inst       = ir;
  assign inst_pc    = ipc;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have ports `clk` in 1, the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port `reset` in 1: synchronous, active-high reset.
REQ-003 The block SHALL have port `imem_req` out 1: instruction memory read request.
REQ-004 The block SHALL have port `imem_addr` out 10: read address, equal to the current fetch PC.
REQ-005 The block SHALL have port `imem_ack` in 1: read data valid; counts only while `imem_req`=1.
REQ-006 The block SHALL have port `imem_rdata` in 9: instruction word, valid when `imem_ack`=1.
REQ-007 The block SHALL have ports `branch` in 1 and `branch_addr` in 10: one-cycle redirect to `branch_addr`.
REQ-008 The block SHALL have ports `jump` in 1 and `jump_target` in 10: one-cycle redirect to `jump_target`.
REQ-009 The block SHALL have port `halt` in 1: while high, no new fetch is issued.
REQ-010 The block SHALL have ports `inst_valid` out 1, `inst` out 9, `inst_pc` out 10: held instruction to decode, and its address.
REQ-011 The block SHALL have port `inst_ready` in 1: decode accepts; a transfer occurs when `inst_valid`=1 and `inst_ready`=1.
REQ-012 The block SHALL have port `pc_out` out 10: current fetch PC.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, REQ, HOLD, HALT.
REQ-014 IDLE SHALL last one cycle, then go to HALT if `halt`=1, else to REQ.
REQ-015 In REQ the block SHALL drive `imem_req`=1 with `imem_addr`=`pc_out`, held stable until `imem_ack`; the request cannot be aborted.
REQ-016 `imem_ack` MAY arrive in the first REQ cycle (zero wait); the block SHALL tolerate any number of wait cycles.
REQ-017 On `imem_ack` in REQ with no redirect pending or present, the block SHALL in that edge:
- latch `inst`<=`imem_rdata` and `inst_pc`<=`pc_out`;
- set `pc_out`<=`pc_out`+1, modulo 1024 (1023 wraps to 0);
- go to HOLD.
REQ-018 In HOLD, `inst_valid` SHALL be 1, with `inst` and `inst_pc` stable, until transfer.
REQ-019 On transfer in HOLD, the block SHALL go to HALT if `halt`=1, else to REQ.
REQ-020 Redirect target SHALL be `jump_target` when `jump`=1 (jump wins over branch), else `branch_addr` when `branch`=1.
REQ-021 A redirect in REQ without ack SHALL set `redir_pend` and store the target; the block SHALL stay in REQ with `imem_addr` unchanged.
REQ-022 A later redirect while `redir_pend`=1 SHALL overwrite the stored target (latest wins).
REQ-023 On `imem_ack` while `redir_pend`=1, or with a redirect in the same cycle, the block SHALL:
- discard `imem_rdata`;
- set `pc_out`<=target (same-cycle redirect overrides the stored one);
- clear `redir_pend`;
- stay in REQ, issuing the new address next cycle.
REQ-024 A redirect in HOLD SHALL drop the held instruction (`inst_valid`=0 next cycle), set `pc_out`<=target, and go to REQ.
- If a transfer occurs in that same cycle, the instruction counts as accepted.
- The redirect takes precedence over `halt` for that cycle.
REQ-025 A redirect in HALT or IDLE SHALL set `pc_out`<=target with no state change caused by the redirect.
REQ-026 HALT SHALL drive `imem_req`=0 and `inst_valid`=0, and go to REQ in the cycle after `halt` is sampled 0.
REQ-027 `halt` SHALL NOT cancel an outstanding REQ or a held instruction; it takes effect only at the transitions in REQ-014, REQ-019 and REQ-026.
REQ-028 `imem_req` and `inst_valid` SHALL be decoded from the state register only, with no combinational path from any input.

Reset
REQ-029 While `reset`=1 at an edge, the block SHALL set:
- state to IDLE;
- `pc_out`, `inst_pc`, `inst`, stored redirect target to 0;
- `redir_pend`, `imem_req`, `inst_valid` to 0.
REQ-030 Reset SHALL take priority over all inputs, including mid-request.
- An `imem_ack` arriving in the cycle after reset deasserts SHALL be ignored, because `imem_req`=0 in IDLE.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset 2 cycles; ack in 1st REQ cycle, rdata=9'h0A5, `inst_ready`=1 -> `imem_addr` 0,1,2 on successive REQ cycles; `inst`=0A5 with `inst_pc`=0; one transfer every 2 cycles.
- Ack delayed 3 cycles -> `imem_addr`=0 and `imem_req`=1 held for 4 cycles; a single HOLD follows.
- `branch`=1, `branch_addr`=100 during the 2nd wait cycle, ack 2 cycles later -> data discarded, `inst_valid` stays 0, next `imem_addr`=100.
- `branch`(200) and `jump`(500) same cycle in HOLD with `inst_ready`=0 -> `inst_valid` drops next cycle; next `imem_addr`=500.
- `inst_ready`=0 for 5 cycles in HOLD -> `inst`/`inst_pc` stable; no `imem_req`; `pc_out` unchanged.
- `halt`=1 at transfer -> HALT with `imem_req`=0; `halt`=0 -> REQ next cycle.
- PC wrap: `jump_target`=1023 -> fetch 1023 then 0.
- `reset` mid-REQ -> all outputs 0 and state IDLE next cycle.
